mem_read_port: RTL
==================

Name: mem_read_port

Overview:
- Read-side companion to the processor's 16-bit write-enabled storage elements.
- Accepts a read request from the multicycle control unit, drives the address to the synchronous data/instruction memory, and waits a fixed memory latency.
- Captures the returned 16-bit word into an internal holding register and presents it with a valid/ack handshake until consumed.
- Sits between the control FSM / MDR path and the memory block.

Parameters:
- ADDR_W, 16, memory address width in bits.
- DATA_W, 16, data word width in bits; data is signed two's complement.
- RD_LATENCY, 2, cycles from address presented to memory data valid; legal range 1..7.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- rd_req  input  1  read request from control unit; qualified by rd_ready.
- rd_addr  input  ADDR_W  address for the read, sampled when rd_req && rd_ready.
- rd_ready  output  1  high when a new request can be accepted (state IDLE).
- mem_addr  output  ADDR_W  address driven to memory, held stable through WAIT.
- mem_re  output  1  memory read enable, high for exactly the first WAIT cycle.
- mem_rdata  input  DATA_W  memory read data, valid RD_LATENCY cycles after mem_re.
- rd_data  output  DATA_W  captured word (signed), stable while rd_valid.
- rd_valid  output  1  captured word available.
- rd_ack  input  1  consumer accepts rd_data; effective only while rd_valid.
- busy  output  1  high in WAIT or HOLD.

Behaviour:
- States: IDLE, WAIT, HOLD.
- Reset (synchronous, overrides everything in that cycle):
  - state goes to IDLE.
  - mem_addr, rd_data and the latency counter go to 0.
  - mem_re, rd_valid and busy go to 0; rd_ready goes to 1.
- IDLE:
  - rd_ready=1.
  - On rd_req=1 at an edge: latch mem_addr<=rd_addr, load counter<=RD_LATENCY, go to WAIT.
  - rd_req=0 stays in IDLE.
- WAIT:
  - mem_re=1 only in the first WAIT cycle; busy=1; rd_ready=0.
  - Counter decrements each cycle.
  - On the edge where counter==1: rd_data<=mem_rdata, go to HOLD.
  - Total: request edge to rd_valid=1 is exactly RD_LATENCY+1 edges.
  - rd_req during WAIT is ignored; it is not queued.
- HOLD:
  - rd_valid=1; rd_data is frozen regardless of mem_rdata changes.
  - On rd_ack=1: go to IDLE; rd_valid drops the next cycle.
  - No back-to-back acceptance in the ack cycle: rd_ready stays 0 in HOLD, so a new rd_req is accepted at the earliest on the cycle after returning to IDLE.
- rd_ack outside HOLD has no effect.
- mem_addr holds its last value in IDLE and HOLD; it changes only on request accept.
- rd_data holds its last captured value after the HOLD exit, until the next capture.
- Reset asserted in WAIT or HOLD aborts the transaction:
  - the captured word is lost and rd_valid=0 after that edge.
  - no further mem_re is issued.
- No arithmetic on data. The counter is 3 bits, never wraps (loaded ≥1, stops at HOLD).
- RD_LATENCY=1 gives a single WAIT cycle in which mem_re=1 and the capture happen together.

Test Plan:
- Reset then idle: hold reset 2 cycles, release; rd_req=0 for 5 cycles -> rd_ready=1, rd_valid=0, mem_re=0, rd_data=0x0000, busy=0 throughout.
- Basic read, RD_LATENCY=2:
  - Stimulus: rd_addr=0x0040 with rd_req one cycle; model memory returns 0xBEEF 2 cycles after mem_re; rd_ack 3 cycles after rd_valid rises.
  - Required: mem_addr=0x0040, a single-cycle mem_re pulse, rd_valid after 3 edges, rd_data=0xBEEF (signed -16657) stable through HOLD, return to IDLE one edge after ack.
- Ignored requests:
  - rd_req with rd_addr=0x1234 during WAIT -> mem_addr stays 0x0040, no second mem_re.
  - After completion -> exactly one transaction recorded.
- Data freeze: change mem_rdata to 0x0001 every cycle while in HOLD -> rd_data stays 0xBEEF until ack.
- Reset mid-operation:
  - Assert reset on the second WAIT cycle -> next cycle state IDLE, rd_valid=0, rd_data=0x0000.
  - A following read of 0x0002 returning 0x7FFF completes normally.
- Parameter sweep: RD_LATENCY=1 and RD_LATENCY=7 -> request-to-valid edges = 2 and 8 respectively; ack held high continuously causes HOLD to last exactly one cycle.

Source files
------------

// File: rtl/mem_read_port_if.sv
// rtl/mem_read_port_if.sv - request/response and memory-side bus of the read port
interface mem_read_port_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic                     rd_req;
  logic        [ADDR_W-1:0] rd_addr;
  logic                     rd_ready;
  logic        [ADDR_W-1:0] mem_addr;
  logic                     mem_re;
  logic        [DATA_W-1:0] mem_rdata;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic                     rd_ack;

  // Environment side: control unit plus memory block
  modport master (
    output rd_req, rd_addr, rd_ack, mem_rdata,
    input  rd_ready, mem_addr, mem_re, rd_data, rd_valid
  );

  // Read port side
  modport slave (
    input  rd_req, rd_addr, rd_ack, mem_rdata,
    output rd_ready, mem_addr, mem_re, rd_data, rd_valid
  );
endinterface

// File: rtl/mem_read_port.sv
// rtl/mem_read_port.sv - fixed-latency memory read port with valid/ack holding register
module mem_read_port #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_read_port_if.slave    bus,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t                   state, state_next;
  logic        [2:0]        count, count_next;
  logic                     accept, capture;
  logic        [ADDR_W-1:0] addr_q;
  logic signed [DATA_W-1:0] data_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, counter update and handshake outputs
  always_comb begin
    state_next    = state;
    count_next    = count;
    accept        = 1'b0;
    capture       = 1'b0;
    bus.rd_ready  = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.mem_re    = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.rd_ready = 1'b1;
        if (bus.rd_req) begin
          accept     = 1'b1;
          count_next = LAT;
          state_next = WAIT;
        end
      end
      WAIT: begin
        busy       = 1'b1;
        // The counter still holds its load value only in the first WAIT cycle
        bus.mem_re = (count == LAT);
        count_next = count - 3'd1;
        if (count == 3'd1) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        busy         = 1'b1;
        bus.rd_valid = 1'b1;
        if (bus.rd_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address latch, latency counter and captured word
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      count <= count_next;
      if (accept)  addr_q <= bus.rd_addr;
      if (capture) data_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.rd_data  = data_q;

endmodule
